// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared definitions for the synchronous audio FIFO: audio-path defaults,
// the clog2 helper and the backpressure state encoding.
package fifo_sync_ctrl_pkg;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_DEPTH    = 1024;
  localparam int DEF_PAUSE_HI = 512;
  localparam int DEF_PAUSE_LO = 256;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pause_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Writer/reader-facing signal bundle of the audio FIFO; master drives the
// requests, slave (the FIFO) drives data and status.
interface fifo_sync_ctrl_if
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CW = clog2(DEPTH) + 1;

  // Handshake: Wr_En/Rd_En are single-cycle requests sampled at every rising
  // clk edge. A read is taken when the FIFO is not empty; a write is taken
  // when not full or when a read is taken at the same edge. Rejected requests
  // are dropped (no retry) and flagged in Overflow/Underflow. Rd_Valid pulses
  // for one cycle, one clock after an accepted read, with Rd_Data.
  logic              Flush;
  logic              Wr_En;
  logic [DATA_W-1:0] Wr_Data;
  logic              Rd_En;
  logic              Clr_Err;
  logic [DATA_W-1:0] Rd_Data;
  logic              Rd_Valid;
  logic [CW-1:0]     Count;
  logic              Empty;
  logic              Full;
  logic              Pausa;
  logic              Overflow;
  logic              Underflow;
  pause_state_e      pause_state;

  modport master (
    output Flush, Wr_En, Wr_Data, Rd_En, Clr_Err,
    input  Rd_Data, Rd_Valid, Count, Empty, Full, Pausa, Overflow, Underflow,
           pause_state
  );

  modport slave (
    input  Flush, Wr_En, Wr_Data, Rd_En, Clr_Err,
    output Rd_Data, Rd_Valid, Count, Empty, Full, Pausa, Overflow, Underflow,
           pause_state
  );

endinterface

// File: rtl/fifo_sync_ctrl_mem.sv
// Simple dual-port RAM: synchronous write port, synchronous read port with a
// registered, resettable output and read enable. Contents are never cleared.
module fifo_sync_ctrl_mem
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO for the I2S audio path: pointers, occupancy, sticky error
// flags and the Pausa backpressure hysteresis around a dual-port RAM.
module fifo_sync_ctrl
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PAUSE_HI = DEF_PAUSE_HI,
  parameter int PAUSE_LO = DEF_PAUSE_LO
) (
  input  logic            clk,
  input  logic            reset,
  fifo_sync_ctrl_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C   = CW'(PAUSE_HI);
  localparam logic [CW-1:0] LO_C   = CW'(PAUSE_LO);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          empty, full;
  logic          rd_acc, wr_acc, rd_go, wr_go;
  logic          ovf_set, unf_set;
  logic          overflow, underflow, rd_valid;
  pause_state_e  state, state_next;

  assign empty  = (count == '0);
  assign full   = (count == FULL_C);
  assign rd_acc = bus.Rd_En & ~empty;
  assign wr_acc = bus.Wr_En & (~full | rd_acc);

  // Flush and reset suppress every transfer and every error set.
  assign rd_go   = rd_acc & ~bus.Flush & ~reset;
  assign wr_go   = wr_acc & ~bus.Flush & ~reset;
  assign ovf_set = bus.Wr_En & full & ~rd_acc & ~bus.Flush;
  assign unf_set = bus.Rd_En & empty & ~bus.Flush;

  always_comb begin
    count_next = count;
    if (bus.Flush) count_next = '0;
    else           count_next = count + CW'(wr_go) - CW'(rd_go);
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (count_next > HI_C) state_next = PAUSE;
      PAUSE:   if (count_next < LO_C) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      state     <= RUN;
    end else begin
      count    <= count_next;
      state    <= state_next;
      rd_valid <= rd_go;
      if (bus.Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_go) wr_ptr <= wr_ptr + 1'b1;
        if (rd_go) rd_ptr <= rd_ptr + 1'b1;
        // A set in the same cycle as Clr_Err wins.
        if (ovf_set)          overflow <= 1'b1;
        else if (bus.Clr_Err) overflow <= 1'b0;
        if (unf_set)          underflow <= 1'b1;
        else if (bus.Clr_Err) underflow <= 1'b0;
      end
    end
  end

  fifo_sync_ctrl_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (wr_go),
    .waddr (wr_ptr),
    .wdata (bus.Wr_Data),
    .re    (rd_go),
    .raddr (rd_ptr),
    .rdata (bus.Rd_Data)
  );

  assign bus.Count       = count;
  assign bus.Empty       = empty;
  assign bus.Full        = full;
  assign bus.Pausa       = (state == PAUSE);
  assign bus.Rd_Valid    = rd_valid;
  assign bus.Overflow    = overflow;
  assign bus.Underflow   = underflow;
  assign bus.pause_state = state;

endmodule
